// File: rtl/accel_pixel_packer_if.sv
// rtl/accel_pixel_packer_if.sv - pixel input stream, packed word output stream and status bundle
interface accel_pixel_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 32,
   parameter int FIFO_DEPTH = 16
);
   logic                             frame_start;
   logic [DATA_WIDTH-1:0]            pixel_in;
   logic                             pixel_in_valid;
   logic [OUT_WIDTH-1:0]             out_data;
   logic                             out_valid;
   logic                             out_ready;
   logic                             out_last;
   logic                             frame_done;
   logic                             overflow_err;
   logic                             misalign_err;
   logic                             err_clr;
   logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level;

   modport slave (
      input  frame_start, pixel_in, pixel_in_valid, out_ready, err_clr,
      output out_data, out_valid, out_last, frame_done, overflow_err, misalign_err, fifo_level
   );

   modport master (
      output frame_start, pixel_in, pixel_in_valid, out_ready, err_clr,
      input  out_data, out_valid, out_last, frame_done, overflow_err, misalign_err, fifo_level
   );
endinterface

// File: rtl/accel_pixel_packer.sv
// rtl/accel_pixel_packer.sv - packs pixels into words, buffers them in a FIFO, tags frame ends
module accel_pixel_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 32,
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   accel_pixel_packer_if.slave  bus
);
   localparam int PACK   = OUT_WIDTH / DATA_WIDTH;
   localparam int TOTAL  = IMG_WIDTH * IMG_HEIGHT;
   localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int CNT_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

   logic [LANE_W-1:0]    r_lane_idx;
   logic [CNT_W-1:0]     r_pix_cnt;
   logic [OUT_WIDTH-1:0] r_hold;
   logic [OUT_WIDTH:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]     r_level;
   logic                 r_frame_done;
   logic                 r_overflow_err;
   logic                 r_misalign_err;

   logic [LANE_W-1:0]    w_lane;
   logic [CNT_W-1:0]     w_cnt;
   logic [OUT_WIDTH-1:0] w_word;
   logic                 w_word_done;
   logic                 w_pix_last;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_misalign;

   // frame_start realigns this very pixel to lane 0 / pixel 0
   assign w_lane      = bus.frame_start ? '0 : r_lane_idx;
   assign w_cnt       = bus.frame_start ? '0 : r_pix_cnt;
   assign w_word_done = bus.pixel_in_valid && (w_lane == LANE_LAST);
   assign w_pix_last  = (w_cnt == CNT_LAST);
   assign w_misalign  = bus.frame_start && (r_lane_idx != '0);

   always_comb begin
      w_word = r_hold;
      w_word[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = bus.pixel_in;
   end

   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);
   assign w_pop   = !w_empty && bus.out_ready;
   // when full, a simultaneous pop frees the slot the new word lands in
   assign w_push  = w_word_done && (!w_full || w_pop);
   assign w_drop  = w_word_done && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane_idx     <= '0;
         r_pix_cnt      <= '0;
         r_hold         <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_frame_done   <= 1'b0;
         r_overflow_err <= 1'b0;
         r_misalign_err <= 1'b0;
      end else begin
         r_frame_done <= bus.pixel_in_valid && w_pix_last;

         if (bus.pixel_in_valid) begin
            r_hold[int'(w_lane)*DATA_WIDTH +: DATA_WIDTH] <= bus.pixel_in;
            r_lane_idx <= (w_lane == LANE_LAST) ? '0 : w_lane + LANE_W'(1);
            r_pix_cnt  <= w_pix_last ? '0 : w_cnt + CNT_W'(1);
         end else begin
            r_lane_idx <= w_lane;
            r_pix_cnt  <= w_cnt;
         end

         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase

         r_overflow_err <= w_drop     || (r_overflow_err && !bus.err_clr);
         r_misalign_err <= w_misalign || (r_misalign_err && !bus.err_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_pix_last, w_word};
   end

   assign bus.out_valid    = !w_empty;
   assign bus.out_data     = w_empty ? '0 : r_mem[r_rd_ptr][OUT_WIDTH-1:0];
   assign bus.out_last     = w_empty ? 1'b0 : r_mem[r_rd_ptr][OUT_WIDTH];
   assign bus.frame_done   = r_frame_done;
   assign bus.overflow_err = r_overflow_err;
   assign bus.misalign_err = r_misalign_err;
   assign bus.fifo_level   = r_level;
endmodule
